// File: rtl/weight_serializer_if.sv
// Upstream word port and bit-serial MAC port of the weight serializer.
// Handshake: a word transfers on a rising edge where in_valid and in_ready are both high.
interface weight_serializer_if #(
  parameter int ACT_WIDTH = 16,
  parameter int W_WIDTH   = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [W_WIDTH-1:0]   in_weight;
  logic [ACT_WIDTH-1:0] in_act;
  logic [3:0]           in_precision;
  logic                 set;
  logic                 valid;
  logic                 w;
  logic [ACT_WIDTH-1:0] act;
  logic [3:0]           precision;
  logic                 last;

  modport slave (
    input  in_valid, in_weight, in_act, in_precision,
    output in_ready, set, valid, w, act, precision, last
  );

  modport master (
    output in_valid, in_weight, in_act, in_precision,
    input  in_ready, set, valid, w, act, precision, last
  );
endinterface

// File: rtl/weight_serializer.sv
// Serializes two's-complement weights LSB first for a bit-serial MAC (IDLE -> SET -> SHIFT).
// Define WSER_PREFETCH_EN to add a one-entry hold register so words run back to back.
module weight_serializer #(
  parameter int ACT_WIDTH = 16,
  parameter int W_WIDTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  weight_serializer_if.slave bus,
  output logic [1:0]         o_dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, SET = 2'd1, SHIFT = 2'd2} state_t;

  localparam logic [3:0] P_MAX = 4'(W_WIDTH);

  state_t               r_state;
  state_t               w_next_state;
  logic [W_WIDTH-1:0]   r_weight;
  logic [ACT_WIDTH-1:0] r_act;
  logic [3:0]           r_prec;
  logic [3:0]           r_cnt;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_load_in;
  logic                 w_in_ready;
  logic [3:0]           w_in_prec;

  // Zero or oversize precision means "full width"; this keeps r_cnt from wrapping.
  assign w_in_prec = (bus.in_precision == 4'd0 || bus.in_precision > P_MAX) ? P_MAX : bus.in_precision;
  assign w_last    = (r_state == SHIFT) && (r_cnt == r_prec - 4'd1);
  assign w_accept  = bus.in_valid && w_in_ready;

`ifdef WSER_PREFETCH_EN
  logic                 r_hold_valid;
  logic [W_WIDTH-1:0]   r_hold_weight;
  logic [ACT_WIDTH-1:0] r_hold_act;
  logic [3:0]           r_hold_prec;
  logic                 w_load_hold;
  logic                 w_hold_push;

  // On the last bit the hold entry drains into the active word, so it can refill that same cycle.
  assign w_in_ready  = !r_hold_valid || w_last;
  assign w_hold_push = w_accept && !w_load_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid  <= 1'b0;
      r_hold_weight <= '0;
      r_hold_act    <= '0;
      r_hold_prec   <= 4'd0;
    end else if (w_hold_push) begin
      r_hold_valid  <= 1'b1;
      r_hold_weight <= bus.in_weight;
      r_hold_act    <= bus.in_act;
      r_hold_prec   <= w_in_prec;
    end else if (w_load_hold) begin
      r_hold_valid  <= 1'b0;
    end
  end
`else
  assign w_in_ready = (r_state == IDLE);
`endif

  always_comb begin
    w_next_state = r_state;
    w_load_in    = 1'b0;
`ifdef WSER_PREFETCH_EN
    w_load_hold  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SET;
          w_load_in    = 1'b1;
        end
      end
      SET: w_next_state = SHIFT;
      SHIFT: begin
        if (w_last) begin
          w_next_state = IDLE;
`ifdef WSER_PREFETCH_EN
          if (r_hold_valid) begin
            w_next_state = SET;
            w_load_hold  = 1'b1;
          end else if (w_accept) begin
            w_next_state = SET;
            w_load_in    = 1'b1;
          end
`endif
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_weight <= '0;
      r_act    <= '0;
      r_prec   <= 4'd0;
      r_cnt    <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (w_load_in) begin
        r_weight <= bus.in_weight;
        r_act    <= bus.in_act;
        r_prec   <= w_in_prec;
        r_cnt    <= 4'd0;
`ifdef WSER_PREFETCH_EN
      end else if (w_load_hold) begin
        r_weight <= r_hold_weight;
        r_act    <= r_hold_act;
        r_prec   <= r_hold_prec;
        r_cnt    <= 4'd0;
`endif
      end else if (r_state == SHIFT) begin
        r_weight <= r_weight >> 1;
        r_cnt    <= r_cnt + 4'd1;
      end
    end
  end

  // Stale word registers stay hidden behind the IDLE gate.
  assign bus.in_ready  = w_in_ready;
  assign bus.set       = (r_state == SET);
  assign bus.valid     = (r_state == SHIFT);
  assign bus.w         = (r_state == SHIFT) && r_weight[0];
  assign bus.last      = w_last;
  assign bus.act       = (r_state == IDLE) ? '0 : r_act;
  assign bus.precision = (r_state == IDLE) ? 4'd0 : r_prec;
  assign o_dbg_state   = r_state;
endmodule

// File: doc/weight_serializer.md
WEIGHT_SERIALIZER -- requirements
Module: weight_serializer

Interface
REQ-001 SHALL have parameter ACT_WIDTH, default 16, activation word width forwarded to the MAC.
REQ-002 SHALL have parameter W_WIDTH, default 8, maximum integer weight width in bits.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream word available.
REQ-006 SHALL have port in_ready  output  1  serializer can accept a word this cycle.
REQ-007 SHALL have port in_weight  input  W_WIDTH  two's-complement weight, right-aligned.
REQ-008 SHALL have port in_act  input  ACT_WIDTH  FP16 activation paired with the weight.
REQ-009 SHALL have port in_precision  input  4  weight bit count P.
REQ-010 SHALL have port set  output  1  one-cycle word-start strobe to the bit-serial MAC.
REQ-011 SHALL have port valid  output  1  w carries a weight bit this cycle.
REQ-012 SHALL have port w  output  1  serial weight bit.
REQ-013 SHALL have port act  output  ACT_WIDTH  activation, held stable from set until the last bit.
REQ-014 SHALL have port precision  output  4  effective P, held stable from set until the last bit.
REQ-015 SHALL have port last  output  1  high with the final (sign) bit of a word.

Function
REQ-016 SHALL accept a word on a rising edge where in_valid and in_ready are both high.
REQ-017 SHALL clamp effective P: in_precision of 0 or above W_WIDTH becomes W_WIDTH.
REQ-018 SHALL implement states IDLE, SET, SHIFT.
REQ-019 IDLE: in_ready=1, set=valid=last=0; on accept go to SET.
REQ-020 SET (one cycle): set=1, valid=0, act and precision driven from the captured word; next state SHIFT.
REQ-021 SHIFT: valid=1 for exactly P consecutive cycles, w = weight bit i in cycle i (i=0..P-1, LSB first), last=1 only when i=P-1.
REQ-022 After the last bit, SHALL go to IDLE (or SET per REQ-030) on the next cycle.
REQ-023 Word latency: accept on edge T yields set at cycle T+1, bit 0 at T+2, last at T+1+P.
REQ-024 SHALL use a 4-bit bit counter; it SHALL never wrap, because the clamp keeps P at or below W_WIDTH.
REQ-025 w, act and precision SHALL be 0 whenever the block is in IDLE with no word pending.
REQ-026 in_valid changes during SET/SHIFT SHALL NOT disturb the word in flight.

Reset
REQ-027 With rst high at a rising edge, state SHALL become IDLE; set, valid, w, last, act, precision SHALL become 0; any held word SHALL be discarded.
REQ-028 Reset asserted mid-word SHALL truncate the word with no further valid pulses; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 A word presented in the same cycle as rst SHALL NOT be accepted.

Configuration
REQ-030 With macro WSER_PREFETCH_EN defined: a one-entry hold register is added; in_ready=1 whenever the hold register is empty, including during SET/SHIFT; after last, a held word SHALL go straight to SET, so set follows last with zero idle cycles; an accept and a hold-to-active transfer in the same cycle SHALL both complete.
REQ-031 Without WSER_PREFETCH_EN: in_ready SHALL be 1 only in IDLE; back-to-back words SHALL have exactly one IDLE cycle between last and the next set.

Verification
REQ-032 Reset, then weight=8'h05, P=4, act=16'h3C00 -> set one cycle, then w=1,0,1,0 with valid, last on 4th bit, act=16'h3C00 throughout.
REQ-033 weight=8'hF9 (-7), P=0 -> precision=8, eight bits 1,0,0,1,1,1,1,1, last on 8th.
REQ-034 Two words P=2 with in_valid held high, prefetch off -> set, 2 bits, 1 idle cycle, set, 2 bits; prefetch on -> no idle cycle between them.
REQ-035 rst asserted during bit 2 of a P=8 word -> next cycle all outputs 0, in_ready=1, no further valid.
REQ-036 P=1, weight=8'h01 -> set, then one cycle with valid=1, w=1 and last=1.
